// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves EX-stage branches against their prediction. Emits
//               predictor updates and checkpoint release/restore, and runs
//               flush plus redirect-handshake recovery on a mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int COUNT_SIZE       = 4,
    parameter int CHECKPOINT_WIDTH = 2,
    parameter int FLUSH_CYCLES     = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic                        i_Stall,
    input  logic                        i_Is_Branch,
    input  logic                        i_Taken,
    input  logic [ADDRESS_WIDTH-1:0]    i_PC,
    input  logic [ADDRESS_WIDTH-1:0]    i_Branch_Target,
    input  logic [1:0]                  i_Predictor,
    input  logic [COUNT_SIZE-1:0]       i_Pattern,
    input  logic [CHECKPOINT_WIDTH-1:0] i_Checkpoint,
    input  logic                        i_Redirect_Ack,
    output logic                        o_Flush,
    output logic                        o_Busy,
    output logic                        o_Redirect_Valid,
    output logic [ADDRESS_WIDTH-1:0]    o_Redirect_PC,
    output logic                        o_Restore_Valid,
    output logic                        o_Release_Valid,
    output logic [CHECKPOINT_WIDTH-1:0] o_Checkpoint,
    output logic                        o_Pred_Update_Valid,
    output logic [COUNT_SIZE-1:0]       o_Pred_Update_Pattern,
    output logic [1:0]                  o_Pred_Update_Value
);

    localparam int c_CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]       c_CNT_INIT = c_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] c_PC_STEP  = ADDRESS_WIDTH'(4);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_FLUSH    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_ACK = 2'd2;

    logic [1:0]                  r_state_q, w_state_d;
    logic [c_CNT_W-1:0]          r_cnt_q, w_cnt_d;
    logic                        r_redirect_valid_q, w_redirect_valid_d;
    logic [ADDRESS_WIDTH-1:0]    r_redirect_pc_q, w_redirect_pc_d;
    logic                        r_restore_q, w_restore_d;
    logic                        r_release_q, w_release_d;
    logic [CHECKPOINT_WIDTH-1:0] r_checkpoint_q, w_checkpoint_d;
    logic                        r_upd_valid_q, w_upd_valid_d;
    logic [COUNT_SIZE-1:0]       r_upd_pattern_q, w_upd_pattern_d;
    logic [1:0]                  r_upd_value_q, w_upd_value_d;

    logic                        w_resolve;
    logic                        w_mispredict;
    logic                        w_ack;
    logic                        w_cnt_zero;
    logic [ADDRESS_WIDTH-1:0]    w_correct_pc;
    logic [1:0]                  w_next_counter;

    // Only IDLE resolves; anything arriving during recovery is wrong-path.
    assign w_resolve    = (r_state_q == c_ST_IDLE) && i_Is_Branch && !i_Stall;
    assign w_mispredict = i_Taken ^ i_Predictor[1];
    assign w_correct_pc = i_Taken ? i_Branch_Target : (i_PC + c_PC_STEP);
    assign w_ack        = r_redirect_valid_q && i_Redirect_Ack;
    assign w_cnt_zero   = (r_cnt_q == '0);

    always_comb begin
        w_next_counter = i_Predictor;
        if (i_Taken) begin
            if (i_Predictor != 2'b11) w_next_counter = i_Predictor + 2'b01;
        end else begin
            if (i_Predictor != 2'b00) w_next_counter = i_Predictor - 2'b01;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) r_state_q <= c_ST_IDLE;
        else         r_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_resolve && w_mispredict) w_state_d = c_ST_FLUSH;
            end
            c_ST_FLUSH: begin
                // A cleared redirect means the ack already arrived during FLUSH.
                if (!i_Stall && w_cnt_zero)
                    w_state_d = (!r_redirect_valid_q || w_ack) ? c_ST_IDLE : c_ST_WAIT_ACK;
            end
            c_ST_WAIT_ACK: begin
                if (w_ack) w_state_d = c_ST_IDLE;
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_Flush = (r_state_q != c_ST_IDLE);
        o_Busy  = (r_state_q != c_ST_IDLE);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        w_cnt_d            = r_cnt_q;
        w_redirect_valid_d = r_redirect_valid_q;
        w_redirect_pc_d    = r_redirect_pc_q;
        w_restore_d        = 1'b0;
        w_release_d        = 1'b0;
        w_checkpoint_d     = r_checkpoint_q;
        w_upd_valid_d      = 1'b0;
        w_upd_pattern_d    = r_upd_pattern_q;
        w_upd_value_d      = r_upd_value_q;

        if (w_resolve) begin
            w_upd_valid_d   = 1'b1;
            w_upd_pattern_d = i_Pattern;
            w_upd_value_d   = w_next_counter;
            w_checkpoint_d  = i_Checkpoint;
            if (w_mispredict) begin
                w_restore_d        = 1'b1;
                w_redirect_valid_d = 1'b1;
                w_redirect_pc_d    = w_correct_pc;
                w_cnt_d            = c_CNT_INIT;
            end else begin
                w_release_d = 1'b1;
            end
        end else begin
            if (w_ack) w_redirect_valid_d = 1'b0;
            if ((r_state_q == c_ST_FLUSH) && !i_Stall && !w_cnt_zero)
                w_cnt_d = r_cnt_q - c_CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_cnt_q            <= '0;
            r_redirect_valid_q <= 1'b0;
            r_redirect_pc_q    <= '0;
            r_restore_q        <= 1'b0;
            r_release_q        <= 1'b0;
            r_checkpoint_q     <= '0;
            r_upd_valid_q      <= 1'b0;
            r_upd_pattern_q    <= '0;
            r_upd_value_q      <= '0;
        end else begin
            r_cnt_q            <= w_cnt_d;
            r_redirect_valid_q <= w_redirect_valid_d;
            r_redirect_pc_q    <= w_redirect_pc_d;
            r_restore_q        <= w_restore_d;
            r_release_q        <= w_release_d;
            r_checkpoint_q     <= w_checkpoint_d;
            r_upd_valid_q      <= w_upd_valid_d;
            r_upd_pattern_q    <= w_upd_pattern_d;
            r_upd_value_q      <= w_upd_value_d;
        end
    end

    assign o_Redirect_Valid      = r_redirect_valid_q;
    assign o_Redirect_PC         = r_redirect_pc_q;
    assign o_Restore_Valid       = r_restore_q;
    assign o_Release_Valid       = r_release_q;
    assign o_Checkpoint          = r_checkpoint_q;
    assign o_Pred_Update_Valid   = r_upd_valid_q;
    assign o_Pred_Update_Pattern = r_upd_pattern_q;
    assign o_Pred_Update_Value   = r_upd_value_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_Stall = 1'b0;
    logic        i_Is_Branch = 1'b0;
    logic        i_Taken = 1'b0;
    logic [31:0] i_PC = '0;
    logic [31:0] i_Branch_Target = '0;
    logic [1:0]  i_Predictor = '0;
    logic [3:0]  i_Pattern = '0;
    logic [1:0]  i_Checkpoint = '0;
    logic        i_Redirect_Ack = 1'b0;
    logic        o_Flush, o_Busy, o_Redirect_Valid, o_Restore_Valid, o_Release_Valid;
    logic [31:0] o_Redirect_PC;
    logic [1:0]  o_Checkpoint, o_Pred_Update_Value;
    logic        o_Pred_Update_Valid;
    logic [3:0]  o_Pred_Update_Pattern;

    int checks = 0;
    int failures = 0;

    branch_resolve_unit #(
        .ADDRESS_WIDTH(32), .COUNT_SIZE(4), .CHECKPOINT_WIDTH(2), .FLUSH_CYCLES(2)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Stall(i_Stall), .i_Is_Branch(i_Is_Branch),
        .i_Taken(i_Taken), .i_PC(i_PC), .i_Branch_Target(i_Branch_Target),
        .i_Predictor(i_Predictor), .i_Pattern(i_Pattern), .i_Checkpoint(i_Checkpoint),
        .i_Redirect_Ack(i_Redirect_Ack), .o_Flush(o_Flush), .o_Busy(o_Busy),
        .o_Redirect_Valid(o_Redirect_Valid), .o_Redirect_PC(o_Redirect_PC),
        .o_Restore_Valid(o_Restore_Valid), .o_Release_Valid(o_Release_Valid),
        .o_Checkpoint(o_Checkpoint), .o_Pred_Update_Valid(o_Pred_Update_Valid),
        .o_Pred_Update_Pattern(o_Pred_Update_Pattern), .o_Pred_Update_Value(o_Pred_Update_Value)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [45:0] all_out;
        i_Is_Branch = 1'b1; i_PC = 32'h40; i_Branch_Target = 32'h80;
        i_Predictor = 2'b10; i_Taken = 1'b0; i_Pattern = 4'hA; i_Checkpoint = 2'd3;
        step();
        i_Is_Branch = 1'b0;
        checks++; if (o_Busy !== 1'b1) begin failures++; $display("FAIL reset_pre_busy got=%b exp=1", o_Busy); end
        #3 rst = 1'b1;
        #1;
        all_out = {o_Flush, o_Busy, o_Redirect_Valid, o_Redirect_PC, o_Restore_Valid, o_Release_Valid,
                   o_Checkpoint, o_Pred_Update_Valid, o_Pred_Update_Pattern, o_Pred_Update_Value};
        checks++; if (all_out !== 46'd0) begin failures++; $display("FAIL reset_async_outputs got=%h exp=0", all_out); end
        step();
        rst = 1'b0;
        step();
        checks++; if ({o_Flush, o_Busy, o_Redirect_Valid} !== 3'b000) begin
            failures++; $display("FAIL reset_after_release got=%b exp=000", {o_Flush, o_Busy, o_Redirect_Valid}); end
    endtask

    task automatic test_correct_taken;
        i_Is_Branch = 1'b1; i_PC = 32'h300; i_Branch_Target = 32'h400;
        i_Predictor = 2'b10; i_Taken = 1'b1; i_Pattern = 4'h5; i_Checkpoint = 2'd1;
        step();
        i_Is_Branch = 1'b0;
        checks++; if ({o_Release_Valid, o_Restore_Valid, o_Pred_Update_Valid} !== 3'b101) begin
            failures++; $display("FAIL taken_pulses got=%b exp=101", {o_Release_Valid, o_Restore_Valid, o_Pred_Update_Valid}); end
        checks++; if (o_Checkpoint !== 2'd1) begin failures++; $display("FAIL taken_checkpoint got=%0d exp=1", o_Checkpoint); end
        checks++; if (o_Pred_Update_Value !== 2'b11) begin failures++; $display("FAIL taken_value got=%b exp=11", o_Pred_Update_Value); end
        checks++; if (o_Pred_Update_Pattern !== 4'h5) begin failures++; $display("FAIL taken_pattern got=%h exp=5", o_Pred_Update_Pattern); end
        checks++; if ({o_Flush, o_Redirect_Valid} !== 2'b00) begin failures++; $display("FAIL taken_no_flush got=%b exp=00", {o_Flush, o_Redirect_Valid}); end
        i_Redirect_Ack = 1'b1;
        step();
        i_Redirect_Ack = 1'b0;
        checks++; if ({o_Release_Valid, o_Pred_Update_Valid, o_Busy} !== 3'b000) begin
            failures++; $display("FAIL taken_pulse_width got=%b exp=000", {o_Release_Valid, o_Pred_Update_Valid, o_Busy}); end
    endtask

    task automatic test_saturation;
        i_Is_Branch = 1'b1; i_Predictor = 2'b11; i_Taken = 1'b1; i_Pattern = 4'h2; i_Checkpoint = 2'd2;
        step();
        checks++; if ({o_Release_Valid, o_Pred_Update_Value} !== 3'b111) begin
            failures++; $display("FAIL sat_high got=%b exp=111", {o_Release_Valid, o_Pred_Update_Value}); end
        i_Predictor = 2'b00; i_Taken = 1'b0; i_Pattern = 4'h9;
        step();
        i_Is_Branch = 1'b0;
        checks++; if ({o_Release_Valid, o_Pred_Update_Valid, o_Pred_Update_Value, o_Pred_Update_Pattern} !== 8'b1100_1001) begin
            failures++; $display("FAIL sat_low got=%b exp=11001001",
                {o_Release_Valid, o_Pred_Update_Valid, o_Pred_Update_Value, o_Pred_Update_Pattern}); end
        step();
    endtask

    task automatic test_mispredict_not_taken;
        i_Is_Branch = 1'b1; i_PC = 32'h100; i_Branch_Target = 32'h500;
        i_Predictor = 2'b10; i_Taken = 1'b0; i_Pattern = 4'h3; i_Checkpoint = 2'd2;
        step();
        i_Is_Branch = 1'b0;
        checks++; if ({o_Restore_Valid, o_Release_Valid, o_Redirect_Valid, o_Flush, o_Busy} !== 5'b10111) begin
            failures++; $display("FAIL mis_flags got=%b exp=10111",
                {o_Restore_Valid, o_Release_Valid, o_Redirect_Valid, o_Flush, o_Busy}); end
        checks++; if (o_Redirect_PC !== 32'h104) begin failures++; $display("FAIL mis_pc got=%h exp=00000104", o_Redirect_PC); end
        checks++; if ({o_Pred_Update_Value, o_Checkpoint} !== 4'b0110) begin
            failures++; $display("FAIL mis_value_cp got=%b exp=0110", {o_Pred_Update_Value, o_Checkpoint}); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if ({o_Redirect_Valid, o_Flush, o_Restore_Valid} !== 3'b110 || o_Redirect_PC !== 32'h104) begin
                failures++; $display("FAIL mis_hold%0d got=%b pc=%h exp=110 pc=00000104", k,
                    {o_Redirect_Valid, o_Flush, o_Restore_Valid}, o_Redirect_PC); end
        end
        i_Redirect_Ack = 1'b1;
        #1;
        checks++; if (o_Flush !== 1'b1) begin failures++; $display("FAIL mis_flush_in_ack_cycle got=%b exp=1", o_Flush); end
        step();
        i_Redirect_Ack = 1'b0;
        checks++; if ({o_Flush, o_Busy, o_Redirect_Valid} !== 3'b000) begin
            failures++; $display("FAIL mis_after_ack got=%b exp=000", {o_Flush, o_Busy, o_Redirect_Valid}); end
    endtask

    task automatic test_early_ack_stall;
        int flush_cycles;
        i_Is_Branch = 1'b1; i_PC = 32'h180; i_Branch_Target = 32'h200;
        i_Predictor = 2'b01; i_Taken = 1'b1; i_Pattern = 4'h6; i_Checkpoint = 2'd0;
        step();
        i_Is_Branch = 1'b0;
        flush_cycles = 0;
        if (o_Flush === 1'b1) flush_cycles++;
        checks++; if ({o_Redirect_Valid, o_Redirect_PC} !== {1'b1, 32'h200}) begin
            failures++; $display("FAIL early_redirect got=%b/%h exp=1/00000200", o_Redirect_Valid, o_Redirect_PC); end
        i_Redirect_Ack = 1'b1;
        // Wrong-path branch presented during recovery, later reused as the first IDLE branch.
        i_Predictor = 2'b10; i_Taken = 1'b1; i_Pattern = 4'h7; i_Checkpoint = 2'd3;
        for (int k = 1; k <= 5; k++) begin
            i_Stall = (k <= 3);
            i_Is_Branch = (k >= 2);
            step();
            i_Redirect_Ack = 1'b0;
            if (o_Flush === 1'b1) flush_cycles++;
            checks++; if ({o_Restore_Valid, o_Release_Valid, o_Pred_Update_Valid, o_Redirect_Valid} !== 4'b0000) begin
                failures++; $display("FAIL early_wrongpath_k%0d got=%b exp=0000", k,
                    {o_Restore_Valid, o_Release_Valid, o_Pred_Update_Valid, o_Redirect_Valid}); end
        end
        checks++; if (flush_cycles != 5) begin failures++; $display("FAIL early_flush_len got=%0d exp=5", flush_cycles); end
        checks++; if ({o_Flush, o_Busy} !== 2'b00) begin failures++; $display("FAIL early_idle got=%b exp=00", {o_Flush, o_Busy}); end
        step();
        i_Is_Branch = 1'b0;
        checks++; if ({o_Release_Valid, o_Checkpoint, o_Pred_Update_Pattern, o_Pred_Update_Value} !== 9'b1_11_0111_11) begin
            failures++; $display("FAIL first_idle_resolve got=%b exp=111011111",
                {o_Release_Valid, o_Checkpoint, o_Pred_Update_Pattern, o_Pred_Update_Value}); end
        step();
    endtask

    task automatic test_stall_wrap;
        i_Is_Branch = 1'b1; i_Stall = 1'b1; i_PC = 32'hFFFF_FFFC; i_Branch_Target = 32'h1234;
        i_Predictor = 2'b11; i_Taken = 1'b0; i_Pattern = 4'hC; i_Checkpoint = 2'd1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if ({o_Restore_Valid, o_Release_Valid, o_Pred_Update_Valid, o_Flush, o_Redirect_Valid} !== 5'b00000) begin
                failures++; $display("FAIL stalled_branch%0d got=%b exp=00000", k,
                    {o_Restore_Valid, o_Release_Valid, o_Pred_Update_Valid, o_Flush, o_Redirect_Valid}); end
        end
        i_Stall = 1'b0;
        step();
        i_Is_Branch = 1'b0;
        checks++; if ({o_Restore_Valid, o_Redirect_Valid, o_Redirect_PC, o_Pred_Update_Value} !== {2'b11, 32'h0, 2'b10}) begin
            failures++; $display("FAIL wrap got=%b/%b/%h/%b exp=1/1/00000000/10",
                o_Restore_Valid, o_Redirect_Valid, o_Redirect_PC, o_Pred_Update_Value); end
        i_Redirect_Ack = 1'b1;
        step();
        i_Redirect_Ack = 1'b0;
        checks++; if ({o_Redirect_Valid, o_Flush} !== 2'b01) begin
            failures++; $display("FAIL wrap_ack_in_flush got=%b exp=01", {o_Redirect_Valid, o_Flush}); end
        step();
        checks++; if ({o_Flush, o_Busy} !== 2'b00) begin failures++; $display("FAIL wrap_idle got=%b exp=00", {o_Flush, o_Busy}); end
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_correct_taken();
        test_saturation();
        test_mispredict_not_taken();
        test_early_ack_stall();
        test_stall_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits at the EX end of the dec/ex pipeline register and consumes its branch fields: Is_Branch, PC, Branch_Target, Predictor, Pattern and Checkpoint.
- Compares each resolved branch outcome against its prediction and produces the predictor update and the checkpoint release or restore.
- On a mispredict, runs a recovery sequence that drives the pipeline Flush inputs and a handshaked fetch redirect.

Parameters:
- ADDRESS_WIDTH, 32, PC and target width
- COUNT_SIZE, 4, branch history pattern width
- CHECKPOINT_WIDTH, 2, rename checkpoint tag width
- FLUSH_CYCLES, 2, minimum number of non-stalled cycles o_Flush stays high per mispredict (>=1)

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge
- i_Reset  in  1  reset, asynchronous, active-high
- i_Stall  in  1  pipeline stall, same signal that drives the pipe stages
- i_Is_Branch  in  1  EX-stage instruction is a branch
- i_Taken  in  1  ALU-resolved branch outcome
- i_PC  in  ADDRESS_WIDTH  branch PC
- i_Branch_Target  in  ADDRESS_WIDTH  taken target
- i_Predictor  in  2  2-bit counter used for the prediction; bit1 = predicted taken
- i_Pattern  in  COUNT_SIZE  history index of the counter
- i_Checkpoint  in  CHECKPOINT_WIDTH  rename checkpoint taken for this branch
- i_Redirect_Ack  in  1  fetch accepted the redirect
- o_Flush  out  1  flush request to the pipe stages
- o_Busy  out  1  recovery in progress
- o_Redirect_Valid  out  1  redirect request, held until acknowledged
- o_Redirect_PC  out  ADDRESS_WIDTH  corrected fetch PC
- o_Restore_Valid  out  1  one-cycle pulse: restore the checkpoint
- o_Release_Valid  out  1  one-cycle pulse: free the checkpoint (correct prediction)
- o_Checkpoint  out  CHECKPOINT_WIDTH  tag for the restore or release
- o_Pred_Update_Valid  out  1  one-cycle pulse: write the predictor
- o_Pred_Update_Pattern  out  COUNT_SIZE  predictor index
- o_Pred_Update_Value  out  2  new counter value

Behaviour:
- Reset: every output is 0, the state is IDLE and the flush counter is 0. Reset asserted mid-recovery aborts immediately, with no pending redirect retained.
- A resolve occurs in a cycle where the state is IDLE, i_Is_Branch=1 and i_Stall=0.
  - A branch presented while i_Stall=1 is not resolved; it is re-presented later.
  - Branches presented in FLUSH or WAIT_ACK are wrong-path and are ignored entirely.
- Mispredict = i_Taken XOR i_Predictor[1].
- Correct PC = i_Taken ? i_Branch_Target : i_PC+4. The addition is modulo 2^ADDRESS_WIDTH.
- Registered outputs, available the cycle after a resolve:
  - o_Pred_Update_Valid is a 1-cycle pulse with o_Pred_Update_Pattern = i_Pattern.
  - The update value saturates: taken gives min(3, p+1), not-taken gives max(0, p-1).
  - o_Checkpoint = i_Checkpoint.
  - Correct prediction: o_Release_Valid pulses for 1 cycle and the state stays IDLE.
  - Mispredict: o_Restore_Valid pulses for 1 cycle, o_Redirect_Valid=1, o_Redirect_PC=correct PC, o_Flush=1, o_Busy=1, counter=FLUSH_CYCLES-1, and the state goes to FLUSH.
- FLUSH state:
  - o_Flush=1 and o_Busy=1.
  - The counter decrements only on cycles with i_Stall=0; the stall dominates, matching the pipe stage priority.
  - On a non-stalled cycle with counter=0, the next state is IDLE if the ack is already latched, otherwise WAIT_ACK.
- WAIT_ACK state: o_Flush=1 and o_Busy=1 until i_Redirect_Ack is sampled; then the next state is IDLE and o_Flush/o_Busy drop.
- Redirect handshake:
  - o_Redirect_Valid and o_Redirect_PC stay stable from assertion until i_Redirect_Ack=1 is sampled on a clock edge; o_Redirect_Valid clears on that edge.
  - Ack is ignored while o_Redirect_Valid=0.
  - An ack during FLUSH is latched, so FLUSH still completes its full count.
- Simultaneous events:
  - An ack and the counter reaching 0 on the same non-stalled edge go directly to IDLE.
  - A new branch on the first IDLE cycle after recovery is resolved normally.
- Pulse outputs (Restore, Release, Pred_Update) are never held by i_Stall; each is high for exactly one cycle per resolve.

Test Plan:
- Reset: assert i_Reset asynchronously mid-cycle -> all outputs 0 immediately; state IDLE after release.
- Correct taken: Predictor=2'b10, Taken=1, Pattern=4'h5, Checkpoint=1 -> next cycle Release_Valid pulse, Checkpoint=1, Pred_Update_Value=2'b11, Pattern=5; no Flush.
- Saturation: Predictor=2'b11 with Taken=1 -> value 2'b11. Predictor=2'b00 with Taken=0 -> value 2'b00 and Release pulse.
- Mispredict not-taken: PC=32'h100, Predictor=2'b10, Taken=0, ack 5 cycles later -> Restore pulse and Redirect_PC=32'h104. Redirect_Valid holds until the ack edge. Flush is high exactly through the ack cycle, then IDLE. Pred_Update_Value=2'b01.
- Early ack and stall, with FLUSH_CYCLES=2: mispredict to target 32'h200 with ack on the first cycle and i_Stall high for 3 cycles -> Redirect clears after the ack. Flush lasts 2 non-stalled cycles (5 total). A branch presented during recovery produces no pulses.
- Stalled branch and PC wrap: i_Is_Branch with i_Stall=1 -> no outputs. Then PC=32'hFFFFFFFC, predicted taken, actually not-taken, unstalled -> Redirect_PC=32'h00000000.
